// File: rtl/vending_pkg.sv
// Shared vending definitions: coin codes, unit values, dispenser states.
// Used by change_dispenser and vending_machine.
package vending_pkg;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;
  localparam logic [1:0] CHG_15   = 2'b11;

  localparam logic [1:0] UNIT_5   = 2'd1;
  localparam logic [1:0] UNIT_10  = 2'd2;
  localparam logic [1:0] UNIT_15  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } disp_state_t;

  function automatic logic [1:0] chg_units(
    input logic [1:0] code
  );
    logic [1:0] u;
    u = 2'd0;
    unique case (code)
      CHG_NONE: u = 2'd0;
      CHG_5:    u = UNIT_5;
      CHG_10:   u = UNIT_10;
      CHG_15:   u = UNIT_15;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// Down-counter shared by the fire pulse and the coin wait timeout.
// expire is high during the last counted cycle (count == 1).
module dispense_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: tracks owed credit and drives the 5/10 coin hoppers,
// with fire pulse, exit-sensor wait timeout and fault recovery.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int FIRE_CYCLES = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] change,
  input  logic       coin_seen,
  input  logic       empty5,
  input  logic       empty10,
  input  logic       clr_fault,
  output logic       fire5,
  output logic       fire10,
  output logic [4:0] pending,
  output logic       busy,
  output logic       fault,
  output logic       stall,
  output logic       ovf
);

  localparam logic [7:0] FIRE_LEN = 8'(FIRE_CYCLES);
  localparam logic [7:0] WAIT_LEN = 8'(TIMEOUT);

  disp_state_t state, state_nx;
  logic        sel10, sel10_nx;
  logic        can10, can5;
  logic        credit;
  logic [1:0]  add, sub;
  logic [5:0]  gross, net;
  logic        sat;
  logic        t_load, t_count, t_exp;
  logic [7:0]  t_val;

  assign can10  = (pending >= 5'd2) && !empty10;
  assign can5   = (pending != 5'd0) && !empty5;
  assign credit = coin_seen &&
                  (state == ST_FIRE || state == ST_WAIT);

  assign add   = chg_units(change);
  assign sub   = credit ? (sel10 ? UNIT_10 : UNIT_5) : 2'd0;
  assign gross = {1'b0, pending} + {4'b0, add};
  // Never go below zero even if credit outruns the ledger.
  assign net   = ({4'b0, sub} > gross) ? 6'd0
               : gross - {4'b0, sub};
  assign sat   = net > 6'd31;

  dispense_timer #(.W(8)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .count    (t_count),
    .expire   (t_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      sel10   <= 1'b0;
      pending <= 5'd0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      sel10   <= sel10_nx;
      pending <= sat ? 5'd31 : net[4:0];
      if (sat) ovf <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    sel10_nx = sel10;
    t_load   = 1'b0;
    t_val    = FIRE_LEN;
    t_count  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (can10) begin
          sel10_nx = 1'b1;
          state_nx = ST_FIRE;
          t_load   = 1'b1;
        end else if (can5) begin
          sel10_nx = 1'b0;
          state_nx = ST_FIRE;
          t_load   = 1'b1;
        end
      end
      ST_FIRE: begin
        if (coin_seen) begin
          state_nx = ST_IDLE;
        end else if (t_exp) begin
          state_nx = ST_WAIT;
          t_load   = 1'b1;
          t_val    = WAIT_LEN;
        end else begin
          t_count  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (coin_seen) state_nx = ST_IDLE;
        else if (t_exp) state_nx = ST_FAULT;
        else t_count = 1'b1;
      end
      ST_FAULT: begin
        if (clr_fault) state_nx = ST_IDLE;
      end
    endcase
  end

  assign fire10 = (state == ST_FIRE) && sel10;
  assign fire5  = (state == ST_FIRE) && !sel10;
  assign busy   = (state == ST_FIRE) || (state == ST_WAIT);
  assign fault  = (state == ST_FAULT);
  assign stall  = (state == ST_IDLE) && (pending != 5'd0)
               && !can10 && !can5;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: cycle-by-cycle vector table
// plus hand sequences for timeout, saturation and mid-fire reset.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] change;
  logic       coin_seen, empty5, empty10, clr_fault;
  logic       fire5, fire10, busy, fault, stall, ovf;
  logic [4:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  change_dispenser #(.FIRE_CYCLES(4), .TIMEOUT(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .change    (change),
    .coin_seen (coin_seen),
    .empty5    (empty5),
    .empty10   (empty10),
    .clr_fault (clr_fault),
    .fire5     (fire5),
    .fire10    (fire10),
    .pending   (pending),
    .busy      (busy),
    .fault     (fault),
    .stall     (stall),
    .ovf       (ovf)
  );

  typedef struct {
    logic       rst;
    logic [1:0] chg;
    logic       coin;
    logic       e5;
    logic       e10;
    logic       clr;
    logic [4:0] p;
    logic       f5;
    logic       f10;
    logic       bsy;
    logic       stl;
    logic       flt;
    logic       ov;
  } vec_t;

  vec_t vecs[$];

  task automatic row(
    input logic r, input logic [1:0] c, input logic cs,
    input logic e5i, input logic e10i, input logic cl,
    input logic [4:0] p, input logic f5, input logic f10,
    input logic b, input logic s, input logic f, input logic o
  );
    vec_t v;
    v.rst = r; v.chg = c; v.coin = cs; v.e5 = e5i;
    v.e10 = e10i; v.clr = cl; v.p = p; v.f5 = f5;
    v.f10 = f10; v.bsy = b; v.stl = s; v.flt = f; v.ov = o;
    vecs.push_back(v);
  endtask

  task automatic check(
    input string name, input int got, input int exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs();
    return int'({pending, fire5, fire10, busy, stall, fault, ovf});
  endfunction

  initial begin
    rst = 1'b0; change = 2'b00; coin_seen = 1'b0;
    empty5 = 1'b0; empty10 = 1'b0; clr_fault = 1'b0;

    //   rst chg  cs e5 e10 clr  p  f5 f10 b  s  f  o
    // change=10 through reset, one 10-coin dispensed
    row(0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 2'b10, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0);
    row(1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // change=11: 10-coin then 5-coin (5 credited inside FIRE)
    row(1, 2'b11, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 3, 0, 1, 1, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 3, 0, 1, 1, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 3, 0, 1, 1, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 3, 0, 1, 1, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0);
    row(1, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    row(1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // empty10: two 5-coins; both empty: stall
    row(1, 2'b10, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0);
    row(1, 2'b00, 0, 0, 1, 0, 2, 1, 0, 1, 0, 0, 0);
    row(1, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    row(1, 2'b00, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0);
    row(1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 2'b10, 0, 1, 1, 0, 2, 0, 0, 0, 1, 0, 0);
    row(1, 2'b00, 0, 1, 1, 0, 2, 0, 0, 0, 1, 0, 0);
    row(1, 2'b00, 0, 0, 1, 0, 2, 1, 0, 1, 0, 0, 0);
    row(1, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    row(1, 2'b00, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    // coin_seen in IDLE is ignored
    row(1, 2'b00, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    row(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; change = vecs[i].chg;
      coin_seen = vecs[i].coin; empty5 = vecs[i].e5;
      empty10 = vecs[i].e10; clr_fault = vecs[i].clr;
      step();
      check($sformatf("vec%0d", i), outs(),
        int'({vecs[i].p, vecs[i].f5, vecs[i].f10, vecs[i].bsy,
              vecs[i].stl, vecs[i].flt, vecs[i].ov}));
    end

    // WAIT timeout -> FAULT, then recovery
    begin
      int n = 0;
      int waits = 0;
      change = 2'b10; step();
      change = 2'b00; step();
      check("to_fire", int'(fire10), 1);
      while (!fault && n < 400) begin
        step();
        n++;
        if (busy && !fire5 && !fire10) waits++;
      end
      check("timeout_len", waits, 255);
      check("fault_set", int'(fault), 1);
      check("fault_pend", int'(pending), 2);
      check("fault_fire", int'({fire5, fire10, busy}), 0);
      coin_seen = 1'b1; step(); coin_seen = 1'b0;
      check("coin_in_fault", int'({pending, fault}), int'({5'd2, 1'b1}));
      change = 2'b01; step(); change = 2'b00;
      check("chg_in_fault", int'({pending, fault}), int'({5'd3, 1'b1}));
      clr_fault = 1'b1; step(); clr_fault = 1'b0;
      check("clr_fault", int'({fault, busy}), 0);
      step();
      check("resume", int'({fire5, fire10}), 1);
      coin_seen = 1'b1; step(); coin_seen = 1'b0;
      check("resume_credit", int'(pending), 1);
      rst = 1'b0; step(); rst = 1'b1; step();
    end

    // saturation and simultaneous add/sub
    change = 2'b11;
    for (int k = 0; k < 10; k++) step();
    check("pre_sat", int'({pending, ovf}), int'({5'd30, 1'b0}));
    step();
    change = 2'b00;
    check("sat", int'({pending, ovf}), int'({5'd31, 1'b1}));
    check("sat_busy10", int'({busy, fire5}), int'({1'b1, 1'b0}));
    change = 2'b01; coin_seen = 1'b1; step();
    change = 2'b00; coin_seen = 1'b0;
    check("add_sub", int'({pending, ovf}), int'({5'd30, 1'b1}));

    // reset mid-FIRE
    rst = 1'b0; step(); rst = 1'b1;
    check("rst_clear", int'({pending, ovf, busy}), 0);
    change = 2'b10; step(); change = 2'b00; step();
    check("mid_fire", int'(fire10), 1);
    rst = 1'b0; step();
    check("rst_fire", int'({pending, fire5, fire10, busy}), 0);
    rst = 1'b1; step();
    check("rst_after", int'({pending, fire5, fire10, busy}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter FIRE_CYCLES, default 4, giving the hopper fire pulse length in clk cycles (1..15).
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the max cycles in WAIT for a coin before fault (1..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous, active-low.
REQ-005 SHALL have port change, input, 2, the refund code from vending_machine: 00 none, 01 = 1 unit (5), 10 = 2 units (10), 11 = 3 units (15).
REQ-006 SHALL have port coin_seen, input, 1, the exit sensor pulse for one dispensed coin.
REQ-007 SHALL have ports empty5 and empty10, input, 1 each, the hopper-empty flags.
REQ-008 SHALL have port clr_fault, input, 1, which clears FAULT.
REQ-009 SHALL have ports fire5 and fire10, output, 1 each, the hopper motor drives.
REQ-010 SHALL have port pending, output, 5, the owed credit in 5-units.
REQ-011 SHALL have ports busy, fault, stall and ovf, output, 1 each: busy = dispensing; fault = timeout; stall = owed but undispensable; ovf = sticky saturation.

Function
REQ-012 SHALL sample change every cycle; a nonzero code adds its unit value to pending, visible on the next cycle.
REQ-013 SHALL compute pending_next = pending + add - sub, where sub = the value of a coin credited that cycle; simultaneous add and sub SHALL both apply.
REQ-014 SHALL saturate pending at 31; any clipped addition SHALL set ovf, which stays set until reset.
REQ-015 SHALL implement the FSM states IDLE, FIRE, WAIT and FAULT.
REQ-016 IDLE: the FSM SHALL select a 10-coin if pending>=2 and !empty10, else a 5-coin if pending>=1 and !empty5, then go to FIRE on the next cycle; otherwise it SHALL stay in IDLE.
REQ-017 stall SHALL equal (state==IDLE && pending!=0 && no coin selectable), combinationally.
REQ-018 FIRE: the selected fire output SHALL be high for exactly FIRE_CYCLES cycles; the other fire output SHALL stay low; the FSM SHALL then enter WAIT.
REQ-019 coin_seen in FIRE or WAIT SHALL credit the selected coin once (2 or 1 units) and return the FSM to IDLE; coin_seen in FIRE SHALL also end the pulse immediately.
REQ-020 WAIT: TIMEOUT consecutive cycles without coin_seen SHALL move the FSM to FAULT and set fault=1; pending SHALL be unchanged.
REQ-021 FAULT: fire5 and fire10 SHALL be low; clr_fault SHALL return the FSM to IDLE next cycle with fault=0.
REQ-022 coin_seen in IDLE or FAULT SHALL be ignored and SHALL NOT change pending.
REQ-023 pending SHALL never underflow; sub SHALL NOT exceed pending.
REQ-024 busy SHALL be 1 in FIRE and WAIT, else 0.
REQ-025 change input SHALL be accepted in every state, including FAULT.

Reset
REQ-026 rst low at a clock edge SHALL force the FSM to IDLE, pending=0, ovf=0, fault=0, fire5=fire10=0, busy=0 and clear the timers.
REQ-027 reset mid-FIRE SHALL drop the fire output on the same edge; the owed credit SHALL be lost.

Structure
REQ-028 A shared package vending_pkg SHALL hold the coin code constants (CHG_NONE/5/10/15), the unit values and the FSM state encodings, also used by vending_machine.
REQ-029 The FIRE-length and WAIT-timeout counting SHALL be a single sub-module, dispense_timer (load, count, expire).

Verification
REQ-030 Reset with change=10 -> after release, pending=2; next cycle fire10=1 for 4 cycles; coin_seen in WAIT -> pending=0, busy=0.
REQ-031 change=11 with both hoppers full -> fire10 then fire5 sequence; pending goes 3 -> 1 -> 0.
REQ-032 pending=2 with empty10=1 -> two fire5 pulses; with empty5=1 as well -> stall=1, no fire.
REQ-033 No coin_seen for 255 cycles in WAIT -> fault=1, pending unchanged; clr_fault -> IDLE, dispensing resumes.
REQ-034 change=11 applied 11 times with no coin_seen -> pending=31, ovf=1; change=01 in the same cycle as a 10-coin coin_seen -> pending +1 -2.
REQ-035 rst low during FIRE -> fire low, pending=0 on the following cycle.
